// File: rtl/pdm_audio_tx.sv
// First-order sigma-delta PDM transmitter fed by a small sample FIFO over valid/ready.
// Define PDM_TX_DITHER_EN to add a 16-bit LFSR carry-in that breaks idle tones.
module pdm_audio_tx #(
  parameter int FREQ_DIV   = 32,
  parameter int OSR        = 128,
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  output logic                pdm_o,
  output logic                bit_tick_o,
  output logic                underrun_o
);
  localparam int DIV_W = $clog2(FREQ_DIV);
  localparam int BIT_W = $clog2(OSR);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FREQ_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(OSR - 1);
  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Accumulator update: the carry out of this sum is the PDM bit.
  function automatic logic [SAMPLE_W:0] mod_sum(input logic [SAMPLE_W-1:0] acc,
                                                input logic [SAMPLE_W-1:0] smp,
                                                input logic                cin);
    return {1'b0, acc} + {1'b0, smp} + {{SAMPLE_W{1'b0}}, cin};
  endfunction

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, fifo_empty;
  logic [SAMPLE_W-1:0] fifo_head;

  logic [1:0]          state_q, state_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bitc_q, bitc_d;
  logic                pdm_q, pdm_d;
  logic                tick_q, tick_d;
  logic                under_q, under_d;
  logic                cin;
  logic [SAMPLE_W:0]   sum;

  assign sample_ready_o = (count_q != CNT_FULL);
  assign push           = sample_valid_i & sample_ready_o;
  assign fifo_empty     = (count_q == '0);
  assign fifo_head      = mem_q[rd_ptr_q];

  assign pdm_o      = pdm_q;
  assign bit_tick_o = tick_q;
  assign underrun_o = under_q;

`ifdef PDM_TX_DITHER_EN
  logic [15:0] lfsr_q;

  // x^16+x^14+x^13+x^11+1, stepped once per emitted bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else if (tick_d) begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign cin = lfsr_q[0];
`else
  assign cin = 1'b0;
`endif

  assign sum = mod_sum(acc_q, cur_q, cin);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cur_d   = cur_q;
    div_d   = div_q;
    bitc_d  = bitc_q;
    pdm_d   = pdm_q;
    tick_d  = 1'b0;
    under_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_LOAD: begin
        state_d = ST_RUN;
        if (fifo_empty) begin
          cur_d   = MIDSCALE;
          under_d = 1'b1;
        end else begin
          cur_d = fifo_head;
          pop   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cur_d   = '0;
          div_d   = '0;
          bitc_d  = '0;
          pdm_d   = 1'b0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          pdm_d  = sum[SAMPLE_W];
          acc_d  = sum[SAMPLE_W-1:0];
          tick_d = 1'b1;
          // Last bit of the frame already used the old sample; swap in the next one.
          if (bitc_q == BIT_LAST) begin
            bitc_d = '0;
            if (fifo_empty) begin
              under_d = 1'b1;
            end else begin
              cur_d = fifo_head;
              pop   = 1'b1;
            end
          end else begin
            bitc_d = bitc_q + BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        acc_d   = '0;
        div_d   = '0;
        bitc_d  = '0;
        pdm_d   = 1'b0;
        state_d = en_i ? ST_LOAD : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cur_q    <= '0;
      div_q    <= '0;
      bitc_q   <= '0;
      pdm_q    <= 1'b0;
      tick_q   <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      acc_q    <= acc_d;
      cur_q    <= cur_d;
      div_q    <= div_d;
      bitc_q   <= bitc_d;
      pdm_q    <= pdm_d;
      tick_q   <= tick_d;
      under_q  <= under_d;
    end
  end

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Randomized bench for pdm_audio_tx against a frame-level sigma-delta reference model.
// Honours PDM_TX_DITHER_EN so the same bench covers the dithered build.
module tb_pdm_audio_tx;
  localparam int FREQ_DIV   = 4;
  localparam int OSR        = 16;
  localparam int SAMPLE_W   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FULL_SCALE = 1 << SAMPLE_W;

  logic clk = 1'b0;
  logic rst_n, en, valid, ready, pdm, tick, under;
  logic [SAMPLE_W-1:0] sample;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int en_cyc   = 0;
  int n_under  = 0;
  int exp_under = 0;
  int mdl_lfsr = 'hACE1;
  int obs_bits[$];
  int tick_cyc[$];
  int mdl_fifo[$];
  int exp_bits[$];

  pdm_audio_tx #(
    .FREQ_DIV(FREQ_DIV), .OSR(OSR), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sample_i(sample),
    .sample_valid_i(valid), .sample_ready_o(ready), .pdm_o(pdm),
    .bit_tick_o(tick), .underrun_o(under)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tick === 1'b1) begin
      obs_bits.push_back(int'(pdm));
      tick_cyc.push_back(cyc);
    end
    if (under === 1'b1) n_under++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sample(input int s);
    int w = 0;
    valid  = 1'b1;
    sample = SAMPLE_W'(s);
    while (ready !== 1'b1 && w < 50) begin
      step(1);
      w++;
    end
    check_val("push_ready", 32'(ready), 1);
    step(1);
    valid = 1'b0;
    mdl_fifo.push_back(s);
  endtask

  task automatic start_run();
    obs_bits.delete();
    tick_cyc.delete();
    n_under = 0;
    en      = 1'b1;
    en_cyc  = cyc;
  endtask

  task automatic wait_bits(input int n);
    int w = 0;
    while (obs_bits.size() < n && w < n * FREQ_DIV + 20) begin
      step(1);
      w++;
    end
    check_val("bits_arrived", 32'(obs_bits.size() >= n), 1);
  endtask

  task automatic stop_run();
    int sz;
    en = 1'b0;
    step(1);
    check_val("pdm_muted", 32'(pdm), 0);
    sz = obs_bits.size();
    step(3 * FREQ_DIV);
    check_val("no_tick_when_off", obs_bits.size(), sz);
  endtask

  // Frame-level reference: one sample per OSR bits, carry of acc+sample is the output bit.
  task automatic model_run(input int n);
    int acc = 0;
    int cur = 0;
    int sum = 0;
    int cin = 0;
    exp_bits.delete();
    exp_under = 0;
    if (mdl_fifo.size() > 0) cur = mdl_fifo.pop_front();
    else begin
      cur = FULL_SCALE / 2;
      exp_under++;
    end
    for (int k = 1; k <= n; k++) begin
      cin = 0;
`ifdef PDM_TX_DITHER_EN
      cin = mdl_lfsr & 1;
      mdl_lfsr = (mdl_lfsr >> 1) |
                 (((mdl_lfsr ^ (mdl_lfsr >> 2) ^ (mdl_lfsr >> 3) ^ (mdl_lfsr >> 5)) & 1) << 15);
`endif
      sum = acc + cur + cin;
      exp_bits.push_back(sum >= FULL_SCALE ? 1 : 0);
      acc = sum % FULL_SCALE;
      if (k % OSR == 0) begin
        if (mdl_fifo.size() > 0) cur = mdl_fifo.pop_front();
        else exp_under++;
      end
    end
  endtask

  task automatic compare_run(input string tag, input int n);
    model_run(n);
    for (int i = 0; i < n && i < obs_bits.size(); i++)
      check_val({tag, "_bit"}, obs_bits[i], exp_bits[i]);
    check_val({tag, "_underruns"}, n_under, exp_under);
    if (tick_cyc.size() >= n && n > 1) begin
      check_val({tag, "_first_bit_latency"}, tick_cyc[0] - en_cyc, FREQ_DIV + 2);
      check_val({tag, "_bit_spacing"}, tick_cyc[n-1] - tick_cyc[0], (n - 1) * FREQ_DIV);
    end
  endtask

  function automatic int ones_in_frame(input int f);
    int c = 0;
    for (int i = f * OSR; i < (f + 1) * OSR && i < obs_bits.size(); i++) c += obs_bits[i];
    return c;
  endfunction

  initial begin
    int w;
    int s5;
    int same;
    int exp_ones[3] = '{0, 15, 4};
    rst_n  = 1'b0;
    en     = 1'b0;
    valid  = 1'b0;
    sample = '0;
    #3;
    check_val("rst_pdm", 32'(pdm), 0);
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_underrun", 32'(under), 0);
    check_val("rst_ready", 32'(ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // Empty FIFO: midscale fill with underrun at load and at each boundary.
    start_run();
    wait_bits(32);
    compare_run("empty", 32);
`ifndef PDM_TX_DITHER_EN
    for (int i = 0; i < 4; i++) check_val("midscale_pattern", obs_bits[i], i % 2);
`endif
    stop_run();

    // Directed extremes 0, 15, 4.
    push_sample(0);
    push_sample(15);
    push_sample(4);
    start_run();
    wait_bits(48);
    compare_run("seq", 48);
`ifndef PDM_TX_DITHER_EN
    for (int f = 0; f < 3; f++) check_val("ones_per_frame", ones_in_frame(f), exp_ones[f]);
    for (int i = 0; i < 8; i++) check_val("quarter_pattern", obs_bits[32+i], (i % 4 == 3) ? 1 : 0);
`endif
    stop_run();

    // Fill FIFO while idle, hold a fifth sample until the load pop frees a slot.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      check_val("ready_while_filling", 32'(ready), 1);
      push_sample($urandom_range(0, FULL_SCALE - 1));
    end
    s5     = $urandom_range(0, FULL_SCALE - 1);
    valid  = 1'b1;
    sample = SAMPLE_W'(s5);
    step(2);
    check_val("ready_when_full", 32'(ready), 0);
    start_run();
    w = 0;
    while (ready !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    check_val("ready_after_load_pop", w, 2);
    step(1);
    valid = 1'b0;
    mdl_fifo.push_back(s5);
    wait_bits(5 * OSR);
    compare_run("full", 5 * OSR);
    stop_run();

    // Single sample: second frame repeats it after one boundary underrun.
    push_sample($urandom_range(0, FULL_SCALE - 1));
    start_run();
    wait_bits(OSR + 8);
    compare_run("single", OSR + 8);
    check_val("single_underrun_once", n_under, 1);
`ifndef PDM_TX_DITHER_EN
    same = 1;
    for (int i = 0; i < 8; i++) if (obs_bits[OSR+i] != obs_bits[i]) same = 0;
    check_val("single_frame_repeats", same, 1);
`endif
    stop_run();

    // Drop enable mid-frame, then re-enable on the next FIFO entry.
    push_sample($urandom_range(0, FULL_SCALE - 1));
    push_sample($urandom_range(0, FULL_SCALE - 1));
    start_run();
    wait_bits(7);
    compare_run("drop", 7);
    stop_run();
    start_run();
    wait_bits(OSR);
    compare_run("reenable", OSR);
    stop_run();

    // Async reset mid-frame with a full FIFO.
    for (int i = 0; i < FIFO_DEPTH; i++) push_sample($urandom_range(0, FULL_SCALE - 1));
    start_run();
    step(2);
    push_sample($urandom_range(0, FULL_SCALE - 1));
    check_val("ready_full_running", 32'(ready), 0);
    wait_bits(5);
    step(FREQ_DIV - 1);
    check_val("tick_before_reset", 32'(tick), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_tick", 32'(tick), 0);
    check_val("async_rst_pdm", 32'(pdm), 0);
    check_val("async_rst_underrun", 32'(under), 0);
    check_val("async_rst_ready", 32'(ready), 1);
    mdl_fifo.delete();
    mdl_lfsr = 'hACE1;
    en = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    start_run();
    wait_bits(OSR);
    compare_run("post_reset", OSR);
    stop_run();

`ifdef PDM_TX_DITHER_EN
    for (int i = 0; i < FIFO_DEPTH; i++) push_sample(FULL_SCALE / 2);
    start_run();
    wait_bits(4 * OSR);
    compare_run("dither", 4 * OSR);
    for (int f = 0; f < 4; f++) begin
      w = ones_in_frame(f);
      check_val("dither_ones_in_range", 32'(w >= 7 && w <= 9), 1);
    end
    same = 0;
    for (int i = 0; i + 1 < 4 * OSR; i++) if (obs_bits[i] == obs_bits[i+1]) same = 1;
    check_val("dither_not_alternating", same, 1);
    stop_run();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
